// File: rtl/io_decode_arbiter.sv
// rtl/io_decode_arbiter.sv - Dock I/O BASE/MASK window decoder and chip-select arbiter.
// Optional bus-timeout watchdog enabled by defining UBITZ_DEC_TIMEOUT_EN.
module io_decode_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int NUM_WIN     = 16,
    parameter int NUM_SLOTS   = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 iorq_n,
    input  logic                 r_w_,
    input  logic [NUM_SLOTS-1:0] dev_ready_n,
    input  logic                 cfg_we,
    input  logic [7:0]           cfg_addr,
    input  logic [7:0]           cfg_wdata,
    output logic [7:0]           cfg_rdata,
    output logic                 ready_n,
    output logic [NUM_SLOTS-1:0] cs_n,
    output logic                 data_oe_n,
    output logic                 data_dir,
    output logic                 ff_oe_n,
    output logic                 bus_err,
    output logic [2:0]           err_slot,
    output logic [3:0]           win_index,
    output logic                 win_valid
);

    typedef enum logic [2:0] {IDLE, WAITST, ACCESS, DONE, UNMAP} state_t;

    logic [ADDR_W-1:0]  base_q [NUM_WIN];
    logic [ADDR_W-1:0]  base_d [NUM_WIN];
    logic [ADDR_W-1:0]  mask_q [NUM_WIN];
    logic [ADDR_W-1:0]  mask_d [NUM_WIN];
    logic [2:0]         cslot_q [NUM_WIN];
    logic [2:0]         cslot_d [NUM_WIN];
    logic [3:0]         wait_q [NUM_WIN];
    logic [3:0]         wait_d [NUM_WIN];
    logic [NUM_WIN-1:0] en_q, en_d, rd_ok_q, rd_ok_d, wr_ok_q, wr_ok_d;

    state_t             state_q, state_d;
    logic [3:0]         wcnt_q, wcnt_d;
    logic [2:0]         slot_q, slot_d;
    logic               rd_q, rd_d;
    logic [NUM_SLOTS-1:0] cs_n_q, cs_n_d;
    logic               ready_n_q, ready_n_d;
    logic               data_oe_n_q, data_oe_n_d;
    logic               data_dir_q, data_dir_d;
    logic               ff_oe_n_q, ff_oe_n_d;
    logic               bus_err_q, bus_err_d;
    logic [2:0]         err_slot_q, err_slot_d;
    logic [3:0]         win_index_q, win_index_d;
    logic               win_valid_q, win_valid_d;
`ifdef UBITZ_DEC_TIMEOUT_EN
    logic [15:0]        to_cnt_q, to_cnt_d;
`endif

    logic [31:0]        wtmp, rtmp;
    logic               hit_any;
    logic [3:0]         hit_idx, hit_wait;
    logic [2:0]         hit_slot;
    logic [NUM_SLOTS-1:0] sel_oh;
    logic               dev_rdy, cs_on;

    // Byte lanes are merged through a 32-bit view so bytes above ADDR_W fall away on truncation.
    always_comb begin
        base_d  = base_q;
        mask_d  = mask_q;
        cslot_d = cslot_q;
        wait_d  = wait_q;
        en_d    = en_q;
        rd_ok_d = rd_ok_q;
        wr_ok_d = wr_ok_q;
        wtmp    = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            if (cfg_we && cfg_addr[7:4] == 4'(w)) begin
                case (cfg_addr[3:0])
                    4'd0, 4'd1, 4'd2, 4'd3: begin
                        wtmp = 32'(base_q[w]);
                        wtmp[{cfg_addr[1:0], 3'b000} +: 8] = cfg_wdata;
                        base_d[w] = ADDR_W'(wtmp);
                    end
                    4'd4, 4'd5, 4'd6, 4'd7: begin
                        wtmp = 32'(mask_q[w]);
                        wtmp[{cfg_addr[1:0], 3'b000} +: 8] = cfg_wdata;
                        mask_d[w] = ADDR_W'(wtmp);
                    end
                    4'd8: begin
                        en_d[w]    = cfg_wdata[7];
                        cslot_d[w] = cfg_wdata[2:0];
                    end
                    4'd9: begin
                        wr_ok_d[w] = cfg_wdata[1];
                        rd_ok_d[w] = cfg_wdata[0];
                    end
                    4'd10: wait_d[w] = cfg_wdata[3:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cfg_rdata = 8'h00;
        rtmp      = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            if (cfg_addr[7:4] == 4'(w)) begin
                case (cfg_addr[3:0])
                    4'd0, 4'd1, 4'd2, 4'd3: begin
                        rtmp = 32'(base_q[w]);
                        cfg_rdata = rtmp[{cfg_addr[1:0], 3'b000} +: 8];
                    end
                    4'd4, 4'd5, 4'd6, 4'd7: begin
                        rtmp = 32'(mask_q[w]);
                        cfg_rdata = rtmp[{cfg_addr[1:0], 3'b000} +: 8];
                    end
                    4'd8:  cfg_rdata = {en_q[w], 4'b0000, cslot_q[w]};
                    4'd9:  cfg_rdata = {6'b000000, wr_ok_q[w], rd_ok_q[w]};
                    4'd10: cfg_rdata = {4'b0000, wait_q[w]};
                    default: cfg_rdata = 8'h00;
                endcase
            end
        end
    end

    // Descending scan so the lowest matching window is the one left standing.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = 4'd0;
        hit_slot = 3'd0;
        hit_wait = 4'd0;
        for (int w = NUM_WIN - 1; w >= 0; w--) begin
            if (en_q[w] && (((addr ^ base_q[w]) & mask_q[w]) == '0) &&
                (r_w_ ? rd_ok_q[w] : wr_ok_q[w]) && (int'(cslot_q[w]) < NUM_SLOTS)) begin
                hit_any  = 1'b1;
                hit_idx  = 4'(w);
                hit_slot = cslot_q[w];
                hit_wait = wait_q[w];
            end
        end
    end

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            sel_oh[i] = (slot_q == 3'(i));
        end
        dev_rdy = |(dev_ready_n & sel_oh);
        cs_on   = |(sel_oh & ~cs_n_q);
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        slot_d      = slot_q;
        rd_d        = rd_q;
        win_index_d = win_index_q;
        win_valid_d = win_valid_q;
        cs_n_d      = '1;
        ready_n_d   = 1'b1;
        data_oe_n_d = 1'b1;
        data_dir_d  = 1'b0;
        ff_oe_n_d   = 1'b1;
        bus_err_d   = 1'b0;
        err_slot_d  = err_slot_q;
`ifdef UBITZ_DEC_TIMEOUT_EN
        to_cnt_d    = '0;
`endif
        if (iorq_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    win_index_d = hit_idx;
                    win_valid_d = hit_any;
                    slot_d      = hit_slot;
                    rd_d        = r_w_;
                    wcnt_d      = hit_wait;
                    if (!hit_any)               state_d = UNMAP;
                    else if (hit_wait == 4'd0)  state_d = ACCESS;
                    else                        state_d = WAITST;
                end
                WAITST: begin
                    if (wcnt_q == 4'd1) state_d = ACCESS;
                    else                wcnt_d  = wcnt_q - 4'd1;
                end
                ACCESS: begin
                    cs_n_d      = ~sel_oh;
                    data_oe_n_d = 1'b0;
                    data_dir_d  = rd_q;
                    // Device ready only counts once it has actually seen its chip select.
                    if (cs_on && dev_rdy) begin
                        state_d   = DONE;
                        ready_n_d = 1'b0;
                    end
`ifdef UBITZ_DEC_TIMEOUT_EN
                    else if (to_cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                        state_d     = UNMAP;
                        cs_n_d      = '1;
                        data_oe_n_d = 1'b1;
                        data_dir_d  = 1'b0;
                        ready_n_d   = 1'b0;
                        ff_oe_n_d   = ~rd_q;
                        bus_err_d   = 1'b1;
                        err_slot_d  = slot_q;
                    end else begin
                        to_cnt_d = to_cnt_q + 16'd1;
                    end
`endif
                end
                DONE: begin
                    cs_n_d      = ~sel_oh;
                    data_oe_n_d = 1'b0;
                    data_dir_d  = rd_q;
                    ready_n_d   = 1'b0;
                end
                UNMAP: begin
                    ready_n_d = 1'b0;
                    ff_oe_n_d = ~rd_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < NUM_WIN; w++) begin
                base_q[w]  <= '0;
                mask_q[w]  <= '0;
                cslot_q[w] <= '0;
                wait_q[w]  <= '0;
            end
            en_q        <= '0;
            rd_ok_q     <= '0;
            wr_ok_q     <= '0;
            state_q     <= IDLE;
            wcnt_q      <= '0;
            slot_q      <= '0;
            rd_q        <= 1'b0;
            cs_n_q      <= '1;
            ready_n_q   <= 1'b1;
            data_oe_n_q <= 1'b1;
            data_dir_q  <= 1'b0;
            ff_oe_n_q   <= 1'b1;
            bus_err_q   <= 1'b0;
            err_slot_q  <= '0;
            win_index_q <= '0;
            win_valid_q <= 1'b0;
`ifdef UBITZ_DEC_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            base_q      <= base_d;
            mask_q      <= mask_d;
            cslot_q     <= cslot_d;
            wait_q      <= wait_d;
            en_q        <= en_d;
            rd_ok_q     <= rd_ok_d;
            wr_ok_q     <= wr_ok_d;
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            slot_q      <= slot_d;
            rd_q        <= rd_d;
            cs_n_q      <= cs_n_d;
            ready_n_q   <= ready_n_d;
            data_oe_n_q <= data_oe_n_d;
            data_dir_q  <= data_dir_d;
            ff_oe_n_q   <= ff_oe_n_d;
            bus_err_q   <= bus_err_d;
            err_slot_q  <= err_slot_d;
            win_index_q <= win_index_d;
            win_valid_q <= win_valid_d;
`ifdef UBITZ_DEC_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign cs_n      = cs_n_q;
    assign ready_n   = ready_n_q;
    assign data_oe_n = data_oe_n_q;
    assign data_dir  = data_dir_q;
    assign ff_oe_n   = ff_oe_n_q;
    assign bus_err   = bus_err_q;
    assign err_slot  = err_slot_q;
    assign win_index = win_index_q;
    assign win_valid = win_valid_q;

endmodule

// File: tb/tb_io_decode_arbiter.sv
// tb/tb_io_decode_arbiter.sv - scoreboard bench for io_decode_arbiter.
module tb_io_decode_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        iorq_n, r_w_;
    logic [7:0]  dev_ready_n;
    logic        cfg_we;
    logic [7:0]  cfg_addr, cfg_wdata, cfg_rdata;
    logic        ready_n, data_oe_n, data_dir, ff_oe_n, bus_err, win_valid;
    logic [7:0]  cs_n;
    logic [2:0]  err_slot;
    logic [3:0]  win_index;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] cs_n;
        logic       oe;
        logic       ff;
        logic       dir;
        logic [3:0] idx;
        logic       v;
        logic       berr;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    io_decode_arbiter #(
        .ADDR_W(32), .NUM_WIN(4), .NUM_SLOTS(8), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .iorq_n(iorq_n), .r_w_(r_w_),
        .dev_ready_n(dev_ready_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .ready_n(ready_n),
        .cs_n(cs_n), .data_oe_n(data_oe_n), .data_dir(data_dir), .ff_oe_n(ff_oe_n),
        .bus_err(bus_err), .err_slot(err_slot), .win_index(win_index),
        .win_valid(win_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        cfg_addr = a;
        #1;
        chk(name, 32'(cfg_rdata), 32'(exp));
    endtask

    task automatic resync();
        @(posedge clk); #1;
    endtask

    // One complete Host cycle; the ready-time snapshot is left for the monitor.
    task automatic issue(input string name, input logic [31:0] a, input logic rd,
                         input int lat, input int cs_lat, input logic [7:0] e_cs,
                         input logic e_oe, input logic e_ff, input logic e_dir,
                         input logic [3:0] e_idx, input logic e_v, input logic e_berr);
        exp_t e;
        int   first_cs;
        bit   got;
        e.cs_n = e_cs; e.oe = e_oe; e.ff = e_ff; e.dir = e_dir;
        e.idx = e_idx; e.v = e_v; e.berr = e_berr; e.cyc = cyc + 1 + lat;
        exp_q.push_back(e);
        addr = a; r_w_ = rd; iorq_n = 1'b0;
        first_cs = -1; got = 0;
        for (int k = 0; k < lat + 10; k++) begin
            @(posedge clk); #1;
            if (first_cs < 0 && cs_n != 8'hFF) first_cs = k;
            if (ready_n == 1'b0) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s_ready_wait: ready_n=%0b never asserted", name, ready_n);
            if (exp_q.size() > 0) e = exp_q.pop_back();
        end
        chk({name, "_cs_latency"}, 32'(first_cs), 32'(cs_lat));
        iorq_n = 1'b1;
        @(posedge clk); #1;
        chk({name, "_rel_cs"}, 32'(cs_n), 32'hFF);
        chk({name, "_rel_ready"}, 32'(ready_n), 32'h1);
        chk({name, "_rel_oe"}, 32'({data_oe_n, ff_oe_n}), 32'h3);
        chk({name, "_rel_berr"}, 32'(bus_err), 32'h0);
        @(posedge clk); #1;
    endtask

    // Monitor: every falling ready_n consumes one scoreboard entry.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && ready_n == 1'b0 && prev) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL mon_unexpected_ready: ready_n=0 at cycle %0d, none expected", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_cycle", 32'(cyc), 32'(e.cyc));
                    chk("mon_cs_n", 32'(cs_n), 32'(e.cs_n));
                    chk("mon_data_oe_n", 32'(data_oe_n), 32'(e.oe));
                    chk("mon_ff_oe_n", 32'(ff_oe_n), 32'(e.ff));
                    chk("mon_data_dir", 32'(data_dir), 32'(e.dir));
                    chk("mon_win_index", 32'(win_index), 32'(e.idx));
                    chk("mon_win_valid", 32'(win_valid), 32'(e.v));
                    chk("mon_bus_err", 32'(bus_err), 32'(e.berr));
                end
            end
            prev = ready_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
        $fatal(1, "bench hung");
    end

    initial begin
        exp_t e;
        bit   got;
        bit   berr_seen;
        rst = 1'b1; addr = '0; iorq_n = 1'b1; r_w_ = 1'b1; dev_ready_n = 8'hFF;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs_n", 32'(cs_n), 32'hFF);
        chk("rst_ready_oe_ff", 32'({ready_n, data_oe_n, ff_oe_n}), 32'h7);
        chk("rst_dir_berr", 32'({data_dir, bus_err}), 32'h0);
        chk("rst_err_slot", 32'(err_slot), 32'h0);
        chk("rst_win", 32'({win_valid, win_index}), 32'h0);
        rst = 1'b0;
        resync();

        cfg_write(8'h00, 8'h40);
        cfg_write(8'h04, 8'hF0);
        cfg_write(8'h05, 8'hFF);
        cfg_write(8'h08, 8'h82);
        cfg_write(8'h09, 8'h03);
        cfg_write(8'h0B, 8'hFF);
        cfg_write(8'h58, 8'h81);
        rd_chk("rb_base0", 8'h00, 8'h40);
        rd_chk("rb_base1", 8'h01, 8'h00);
        rd_chk("rb_mask1", 8'h05, 8'hFF);
        rd_chk("rb_ctrl", 8'h08, 8'h82);
        rd_chk("rb_perm", 8'h09, 8'h03);
        rd_chk("rb_wait", 8'h0A, 8'h00);
        rd_chk("rb_off11", 8'h0B, 8'h00);
        rd_chk("rb_win5", 8'h58, 8'h00);
        resync();

        issue("rd_w0", 32'h0045, 1'b1, 2, 1, 8'hFB, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);

        cfg_write(8'h10, 8'h40);
        cfg_write(8'h15, 8'hFF);
        cfg_write(8'h18, 8'h84);
        cfg_write(8'h19, 8'h03);
        issue("prio_w0", 32'h0041, 1'b1, 2, 1, 8'hFB, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
        issue("rd_w1", 32'h0085, 1'b1, 2, 1, 8'hEF, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0);

        cfg_write(8'h0A, 8'h03);
        issue("wr_wait3", 32'h0040, 1'b0, 5, 4, 8'hFB, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);

        // Abort inside WAITST: no ready, no chip select, no error.
        addr = 32'h0045; r_w_ = 1'b1; iorq_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        iorq_n = 1'b1;
        berr_seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus_err || ready_n == 1'b0 || cs_n != 8'hFF) berr_seen = 1;
        end
        chk("abort_quiet", 32'(berr_seen), 32'h0);

        issue("rd_unmap", 32'h1234, 1'b1, 1, -1, 8'hFF, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        cfg_write(8'h21, 8'h20);
        cfg_write(8'h25, 8'hF0);
        cfg_write(8'h28, 8'h83);
        cfg_write(8'h29, 8'h01);
        issue("wr_rdonly", 32'h2345, 1'b0, 1, -1, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        issue("rd_w2", 32'h2345, 1'b1, 2, 1, 8'hF7, 1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0);

        cfg_write(8'h0A, 8'h00);
        dev_ready_n = 8'hFB;
`ifdef UBITZ_DEC_TIMEOUT_EN
        issue("timeout", 32'h0045, 1'b1, 17, 1, 8'hFF, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        chk("timeout_err_slot", 32'(err_slot), 32'h2);
`else
        addr = 32'h0045; r_w_ = 1'b1; iorq_n = 1'b0; berr_seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus_err) berr_seen = 1;
        end
        chk("hold_ready_n", 32'(ready_n), 32'h1);
        chk("hold_cs_n", 32'(cs_n), 32'hFB);
        chk("hold_no_berr", 32'(berr_seen), 32'h0);
        chk("hold_err_slot", 32'(err_slot), 32'h0);
        e.cs_n = 8'hFB; e.oe = 1'b0; e.ff = 1'b1; e.dir = 1'b1;
        e.idx = 4'd0; e.v = 1'b1; e.berr = 1'b0; e.cyc = cyc + 1;
        exp_q.push_back(e);
        dev_ready_n = 8'hFF;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (ready_n == 1'b0) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL hold_ready_wait: ready_n=%0b never asserted", ready_n);
            if (exp_q.size() > 0) e = exp_q.pop_back();
        end
        iorq_n = 1'b1;
        resync();
        chk("hold_rel_cs", 32'(cs_n), 32'hFF);
        resync();
`endif

        // Asynchronous reset in the middle of ACCESS.
        dev_ready_n = 8'hFB;
        addr = 32'h0045; r_w_ = 1'b1; iorq_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("mid_access_cs", 32'(cs_n), 32'hFB);
        rst = 1'b1;
        #1;
        chk("arst_cs_n", 32'(cs_n), 32'hFF);
        chk("arst_ready_oe_ff", 32'({ready_n, data_oe_n, ff_oe_n}), 32'h7);
        chk("arst_dir_berr_slot", 32'({data_dir, bus_err, err_slot}), 32'h0);
        chk("arst_win", 32'({win_valid, win_index}), 32'h0);
        iorq_n = 1'b1; dev_ready_n = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0;
        rd_chk("arst_rb_ctrl", 8'h08, 8'h00);
        rd_chk("arst_rb_base", 8'h00, 8'h00);
        resync();
        issue("post_rst_unmap", 32'h0045, 1'b1, 1, -1, 8'hFF, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_decode_arbiter.md
Name: io_decode_arbiter

Overview:
Second-generation Dock I/O decoder/arbiter. Matches Host I/O cycles against NUM_WIN programmable BASE/MASK windows and drives one of NUM_SLOTS active-low chip selects. Per-window wait-state insertion, per-window read/write permission, a bus-timeout watchdog, and configuration readback are included. All logic, configuration included, runs in the single `clk` domain. Sits between Host bus control and the Dock data transceivers; data never passes through the block.

Parameters:
ADDR_W, 32, address width (8..32)
NUM_WIN, 16, decode windows (1..16)
NUM_SLOTS, 8, chip-select outputs (1..8)
TIMEOUT_CYC, 1024, clk cycles in ACCESS before bus error (2..65535)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
addr  in  ADDR_W  Host address
iorq_n  in  1  Host I/O request, active low
r_w_  in  1  1=read, 0=write
dev_ready_n  in  NUM_SLOTS  per-slot ready, 1=ready
cfg_we  in  1  config write strobe
cfg_addr  in  8  config address {win[3:0], off[3:0]}
cfg_wdata  in  8  config write data
cfg_rdata  out  8  config readback, combinational from cfg_addr
ready_n  out  1  Host ready, active low
cs_n  out  NUM_SLOTS  slot chip selects, active low
data_oe_n  out  1  transceiver enable, active low
data_dir  out  1  1=Tiles->Host, 0=Host->Tiles
ff_oe_n  out  1  0xFF driver enable, active low
bus_err  out  1  one-cycle pulse on timeout
err_slot  out  3  slot of last timeout, sticky
win_index  out  4  latched matching window
win_valid  out  1  latched match flag

Behaviour:
- Config map per window w (cfg_addr[7:4]=w): off 0-3 BASE bytes (LE), 4-7 MASK bytes (LE), 8 = {EN[7], SLOT[2:0]}, 9 = {WR_OK[1], RD_OK[0]}, 10 = WAIT[3:0]. Bytes above ADDR_W, off 11-15, and w>=NUM_WIN: write ignored, read 0x00. Write takes effect at the next edge. Reset clears all registers (all windows disabled).
- Match: EN & ((addr^BASE)&MASK)==0 & (r_w_ ? RD_OK : WR_OK). Lowest index wins. SLOT>=NUM_SLOTS counts as no match.
- All outputs are registered.
- Reset values: ready_n=1, cs_n=all 1, data_oe_n=1, ff_oe_n=1, data_dir=0, bus_err=0, err_slot=0, win_index=0, win_valid=0.
- FSM states: IDLE, WAITST, ACCESS, DONE, UNMAP.
- IDLE: iorq_n sampled 0 latches win/slot/dir/win_valid.
  - Match, WAIT=0: -> ACCESS.
  - Match, WAIT>0: -> WAITST with counter=WAIT.
  - No match: -> UNMAP.
- WAITST: decrement counter; at 1 -> ACCESS. cs_n stays high.
- ACCESS: cs_n[slot]=0, data_oe_n=0, data_dir=latched read. dev_ready_n[slot] sampled 1 -> DONE with ready_n=0. Earliest ready_n is 2 edges after the iorq_n-sampled edge. The counter runs from 0 on entry.
- DONE: hold cs_n, data_oe_n, ready_n=0 until iorq_n sampled 1.
- UNMAP: ready_n=0. On a read, ff_oe_n=0 and data_oe_n=1. Hold until iorq_n sampled 1.
- iorq_n sampled 1 in any state -> IDLE at that edge, all strobes deasserted (aborts WAITST/ACCESS; no bus_err).
- cfg writes during a cycle do not alter the latched win/slot.
- data_oe_n and ff_oe_n are never both 0.

Optional Feature:
UBITZ_DEC_TIMEOUT_EN
- Defined: ACCESS counter reaching TIMEOUT_CYC -> UNMAP. bus_err pulses 1 cycle; err_slot=slot; cs_n released; ready_n=0; ff_oe_n=0 on reads.
- Undefined: no counter; ACCESS waits indefinitely; bus_err=0 and err_slot=0 constant.

Test Plan:
- W0 BASE=0x0040 MASK=0xFFF0 SLOT=2 RD/WR, WAIT=0; read 0x0045, dev_ready_n=all 1 -> cs_n[2]=0 one edge after iorq_n, ready_n=0 next edge, data_dir=1, data_oe_n=0; all released after iorq_n high.
- W0 as above plus W1 BASE=0x0040 MASK=0xFF00 SLOT=4; read 0x0041 -> W0 wins, win_index=0, cs_n[4]=1.
- W0 WAIT=3; write 0x0040 -> cs_n[2] asserted 3 cycles later than WAIT=0; data_dir=0.
- Read unmapped 0x1234 -> ff_oe_n=0, ready_n=0 one edge later, cs_n all 1. Write with RD_OK only -> UNMAP, ff_oe_n=1.
- UBITZ_DEC_TIMEOUT_EN, TIMEOUT_CYC=16, dev_ready_n[2]=0 held -> bus_err single pulse after 16 ACCESS cycles, err_slot=2, ff_oe_n=0, cs_n[2]=1.
- rst asserted mid-ACCESS -> all outputs at reset values immediately, config cleared; readback of offset 8 returns 0x00.
